div_iterative: RTL and testbench

//  Sequential radix-2 restoring divider; the inverse operation of mul_array.

---
 rtl/div_pkg.sv | 21 ++
 rtl/adder_nbit.sv | 49 ++++
 rtl/div_iterative.sv | 125 ++++++++++++
 tb/tb_div_iterative.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding and sizing helpers.
package div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        CALC = S_CALC,
        FIX  = S_FIX,
        DONE = S_DONE
    } state_t;

    // Iteration counter runs WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// N-bit adder with carry in/out; behavioural, ripple or parallel-prefix carry.
module adder_nbit #(
    parameter int N            = 8,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    generate
        if (BEHAVIORAL) begin : g_beh
            assign {cout, sum} = a + b + N'(cin);
        end else if (RIPPLE_CARRY) begin : g_ripple
            logic [N:0] c;
            assign c[0] = cin;
            for (genvar i = 0; i < N; i++) begin : g_fa
                assign sum[i]   = a[i] ^ b[i] ^ c[i];
                assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
            end
            assign cout = c[N];
        end else begin : g_prefix
            logic [N-1:0] p, gg, pp;
            logic [N:0]   c;
            assign p = a ^ b;
            // Kogge-Stone style group generate/propagate, updated in place high to low.
            always_comb begin
                gg = a & b;
                pp = p;
                for (int d = 1; d < N; d = d * 2) begin
                    for (int i = N - 1; i >= d; i--) begin
                        gg[i] = gg[i] | (pp[i] & gg[i-d]);
                        pp[i] = pp[i] & pp[i-d];
                    end
                end
            end
            assign c[0] = cin;
            for (genvar i = 0; i < N; i++) begin : g_c
                assign c[i+1] = gg[i] | (pp[i] & cin);
            end
            assign sum  = p ^ c[N-1:0];
            assign cout = c[N];
        end
    endgenerate

endmodule

// File: rtl/div_iterative.sv
// Radix-2 restoring divider with valid/ready handshakes and RISC-V M corner cases.
module div_iterative
    import div_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter bit BEHAVIORAL   = 1'b0,
    parameter bit RIPPLE_CARRY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, qw, bmag;
    logic             neg_q, neg_r;

    logic             special_dz, special_ov;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_cout;
    logic             unused_sum_msb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign special_dz = (divisor == '0);
    assign special_ov = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
    assign a_abs      = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_abs      = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Trial subtraction: {rem, next dividend bit} - |b|; carry out means no borrow.
    assign add_a = {rem, qw[WIDTH-1]};
    assign add_b = ~{1'b0, bmag};

    adder_nbit #(
        .N           (WIDTH + 1),
        .BEHAVIORAL  (BEHAVIORAL),
        .RIPPLE_CARRY(RIPPLE_CARRY)
    ) u_sub (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b1),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign unused_sum_msb = add_sum[WIDTH];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = (special_dz || special_ov) ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            qw          <= '0;
            bmag        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    div_by_zero <= special_dz;
                    overflow    <= special_ov;
                    if (special_dz) begin
                        quotient  <= '1;
                        remainder <= dividend;
                    end else if (special_ov) begin
                        quotient  <= dividend;
                        remainder <= '0;
                    end
                    cnt   <= CNT_INIT;
                    rem   <= '0;
                    qw    <= a_abs;
                    bmag  <= b_abs;
                    neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r <= is_signed && dividend[WIDTH-1];
                end
                CALC: begin
                    rem <= add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                    qw  <= {qw[WIDTH-2:0], add_cout};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    quotient  <= neg_q ? -qw  : qw;
                    remainder <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
// Self-checking bench for div_iterative: directed corner cases plus randomized ops vs a / and % model.
module tb_div_iterative;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         div_by_zero, overflow;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iterative #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer / and % with the RISC-V M corner cases.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (s && sa == -(1 << (W-1)) && sb == -1) begin
            q = a; r = '0; ov = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    // Accept one op and wait for out_valid; lat counts edges including the accepting one.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output int lat);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4*W) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input logic eov, input int lat, input int elat);
        check({tag, ".q"},   32'(quotient),    32'(eq));
        check({tag, ".r"},   32'(remainder),   32'(er));
        check({tag, ".dz"},  32'(div_by_zero), 32'(edz));
        check({tag, ".ov"},  32'(overflow),    32'(eov));
        check({tag, ".lat"}, 32'(lat),         32'(elat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic [W-1:0] a, b, eq, er;
        logic         s, edz, eov;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.in_ready",  32'(in_ready),    32'd1);
        check("rst.out_valid", 32'(out_valid),   32'd0);
        check("rst.q",         32'(quotient),    32'd0);
        check("rst.r",         32'(remainder),   32'd0);
        check("rst.flags",     32'({div_by_zero, overflow}), 32'd0);

        start_op(8'd100, 8'd7, 1'b0, lat);
        check_res("u100_7", 8'h0E, 8'h02, 1'b0, 1'b0, lat, W+2);
        release_op();
        check("handoff.in_ready", 32'(in_ready), 32'd1);

        start_op(8'hF9, 8'h02, 1'b1, lat);
        check_res("s-7_2", 8'hFD, 8'hFF, 1'b0, 1'b0, lat, W+2);
        release_op();
        start_op(8'h07, 8'hFE, 1'b1, lat);
        check_res("s7_-2", 8'hFD, 8'h01, 1'b0, 1'b0, lat, W+2);
        release_op();

        start_op(8'h2A, 8'h00, 1'b0, lat);
        check_res("u_dz", 8'hFF, 8'h2A, 1'b1, 1'b0, lat, 1);
        release_op();
        start_op(8'h2A, 8'h00, 1'b1, lat);
        check_res("s_dz", 8'hFF, 8'h2A, 1'b1, 1'b0, lat, 1);
        release_op();

        start_op(8'h80, 8'hFF, 1'b1, lat);
        check_res("s_ovf", 8'h80, 8'h00, 1'b0, 1'b1, lat, 1);
        release_op();
        start_op(8'h80, 8'hFF, 1'b0, lat);
        check_res("u_80_ff", 8'h00, 8'h80, 1'b0, 1'b0, lat, W+2);
        release_op();

        // Backpressure: result held, new requests ignored.
        start_op(8'd85, 8'd10, 1'b0, lat);
        dividend = 8'h11; divisor = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold.q",         32'(quotient),  32'd8);
            check("hold.r",         32'(remainder), 32'd5);
            check("hold.dz",        32'(div_by_zero), 32'd0);
            check("hold.in_ready",  32'(in_ready),  32'd0);
            check("hold.out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_op();
        check("hold.rel.in_ready",  32'(in_ready),  32'd1);
        check("hold.rel.out_valid", 32'(out_valid), 32'd0);

        // Reset in the 4th CALC cycle.
        dividend = 8'd200; divisor = 8'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.q",         32'(quotient),  32'd0);
        @(posedge clk); #1 rst = 1'b0;
        start_op(8'd100, 8'd7, 1'b0, lat);
        check_res("postrst", 8'h0E, 8'h02, 1'b0, 1'b0, lat, W+2);
        release_op();

        for (int i = 0; i < 3000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 15))
                0: b = '0;
                1: b = '1;
                2: a = {1'b1, {(W-1){1'b0}}};
                3: begin a = {1'b1, {(W-1){1'b0}}}; b = '1; end
                default: ;
            endcase
            model(a, b, s, eq, er, edz, eov);
            start_op(a, b, s, lat);
            check_res($sformatf("rnd%0d", i), eq, er, edz, eov, lat, (edz || eov) ? 1 : W+2);
            release_op();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
